bsg_manycore_mem_responder: RTL
===============================

# bsg_manycore_mem_responder

Word-addressed scratchpad responder on the rx side of a manycore endpoint. It consumes remote requests (loads, masked stores, atomic swaps) from the endpoint's inbound request stream. It performs them on a private synchronous SRAM and drives the returning-data channel exactly one cycle after each request is accepted. It is the serving end of the remote-request path that tiles initiate, used for accelerator and memory-tile endpoints.

## Interface
- data_width_p, 32, request/response data width (multiple of 8)
- addr_width_p, 28, inbound word-address width
- mem_els_p, 1024, SRAM depth in words; mem_addr_width_lp = clog2(mem_els_p)
- clk_i  input  1  clock
- reset_i  input  1  asynchronous, active-high reset
- in_v_i  input  1  request valid
- in_we_i  input  1  1 = store, 0 = load
- in_amo_swap_i  input  1  atomic swap (valid only with in_we_i=1)
- in_addr_i  input  addr_width_p  word address
- in_data_i  input  data_width_p  store/swap data
- in_mask_i  input  data_width_p/8  byte write mask
- in_load_info_i  input  5  {is_unsigned, is_byte, is_hex, part_sel[1:0]}
- in_yumi_o  output  1  request consumed this cycle
- returning_v_o  output  1  response valid (registered)
- returning_data_o  output  data_width_p  load/swap result; 0 for stores
- oob_count_o  output  16  saturating count of out-of-range requests

## Operation
- FSM states: IDLE, AMO_WR.
- IDLE: in_yumi_o = in_v_i. No other stall source.
- Load: SRAM read at in_addr_i[mem_addr_width_lp-1:0]. Result is extracted in the response cycle from the registered load_info:
  - is_byte: byte part_sel[1:0]
  - is_hex: halfword part_sel[1]
  - otherwise the full word
  - Sign extension unless is_unsigned.
- Store: masked byte write. Response data = 0.
- Amo swap: IDLE accepts, reads the old word, and goes to AMO_WR. AMO_WR writes the registered in_data (all bytes) and returns to IDLE. The response carries the old word. in_yumi_o = 0 in AMO_WR.
- Out of range (in_addr_i >= mem_els_p): the request is still accepted. There is no SRAM access and no write. The response is 0. oob_count_o increments, saturating at 0xFFFF. An out-of-range swap does not enter AMO_WR.
- The SRAM has a single port. The AMO_WR write occupies the port, which is why inbound requests are blocked that cycle.

## Timing
- Reset (async assert, sync release):
  - state = IDLE
  - returning_v_o = 0
  - returning_data_o = 0
  - oob_count_o = 0
  - in_yumi_o follows in_v_i combinationally once reset deasserts and the state is IDLE.
  - SRAM contents are not reset.
- Response rule: returning_v_o is 1 exactly in cycle N+1 for a yumi in cycle N. There is no backpressure on the returning channel.
- Throughput:
  - Load/store: 1 per cycle.
  - Swap: 1 per 2 cycles.
  - The swap response is in the AMO_WR cycle; the write commits at the end of that cycle.
- Read-after-write:
  - A store in cycle N followed by a load of the same address in N+1 returns the new data. Same-port SRAM write-then-read ordering applies, so no bypass is needed.
  - A request accepted the cycle after AMO_WR sees the swapped value.
- Reset mid-swap: the state returns to IDLE, the pending write is dropped, and no response is issued.
- oob_count_o updates in the cycle after acceptance.

## Test plan
- Reset, then store 0xDEADBEEF mask 0xF @5, then load word @5 -> yumi each cycle; responses 0 then 0xDEADBEEF, each exactly 1 cycle after its yumi.
- Store 0x000080FF @7. Then:
  - load is_byte part_sel=0 signed -> 0xFFFFFFFF
  - load is_byte part_sel=1 unsigned -> 0x00000080
  - load is_hex part_sel=0 signed -> 0xFFFF80FF
- Store 0x11223344 @9, then store 0xAABBCCDD mask 0b0101 @9, then load -> 0x11BB33DD.
- Swap 0x5 @3 (old 0x9) back-to-back with a load @3 -> swap response 0x9; in_yumi_o low one cycle; load response 0x5.
- Load @mem_els_p and store @0xFFFFFFF -> responses 0, oob_count_o = 2, no SRAM change; 70000 out-of-range requests -> oob_count_o saturates at 0xFFFF.
- Assert reset_i during AMO_WR -> returning_v_o low next cycle; subsequent load of the target shows the pre-swap value.

Source files
------------

// File: rtl/bsg_manycore_mem_responder_if.sv
// Request/response bundle between a manycore endpoint's rx side and its memory responder.
interface bsg_manycore_mem_responder_if #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 28
);
  logic                      in_v_i;
  logic                      in_we_i;
  logic                      in_amo_swap_i;
  logic [addr_width_p-1:0]   in_addr_i;
  logic [data_width_p-1:0]   in_data_i;
  logic [data_width_p/8-1:0] in_mask_i;
  logic [4:0]                in_load_info_i;
  logic                      in_yumi_o;
  logic                      returning_v_o;
  logic [data_width_p-1:0]   returning_data_o;
  logic [15:0]               oob_count_o;

  modport master (
    output in_v_i, in_we_i, in_amo_swap_i, in_addr_i, in_data_i, in_mask_i, in_load_info_i,
    input  in_yumi_o, returning_v_o, returning_data_o, oob_count_o
  );

  modport slave (
    input  in_v_i, in_we_i, in_amo_swap_i, in_addr_i, in_data_i, in_mask_i, in_load_info_i,
    output in_yumi_o, returning_v_o, returning_data_o, oob_count_o
  );
endinterface

// File: rtl/bsg_manycore_mem_responder.sv
// Word-addressed scratchpad responder: loads, masked stores and atomic swaps on a
// single-port synchronous SRAM, with a response exactly one cycle after acceptance.
module bsg_manycore_mem_responder #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 28,
  parameter int mem_els_p    = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  bsg_manycore_mem_responder_if.slave bus_if
);
  localparam int mem_addr_width_lp = $clog2(mem_els_p);
  localparam int byte_lp           = data_width_p / 8;
  localparam logic [addr_width_p-1:0] mem_els_lp = addr_width_p'(mem_els_p);

  typedef enum logic [0:0] {IDLE = 1'b0, AMO_WR = 1'b1} state_e;
  typedef enum logic [1:0] {RESP_ZERO = 2'd0, RESP_LOAD = 2'd1, RESP_WORD = 2'd2} resp_e;

  state_e                        state_q;
  resp_e                         resp_kind_q;
  logic                          returning_v_q;
  logic [4:0]                    load_info_q;
  logic [15:0]                   oob_count_q, oob_count_d;
  logic [mem_addr_width_lp-1:0]  amo_addr_q;
  logic [data_width_p-1:0]       amo_data_q;
  logic [data_width_p-1:0]       rdata_q;
  logic [data_width_p-1:0]       mem_q [mem_els_p];

  logic                          yumi_s, in_range_s, mem_re_s, mem_we_s;
  logic [byte_lp-1:0]            mem_be_s;
  logic [mem_addr_width_lp-1:0]  mem_idx_s, mem_widx_s;
  logic [data_width_p-1:0]       mem_wdata_s, load_s, resp_data_s;
  logic [7:0]                    byte_s;
  logic [15:0]                   half_s;

  // The AMO_WR write owns the single SRAM port, so nothing is accepted that cycle.
  assign yumi_s      = (state_q == IDLE) & bus_if.in_v_i & ~reset_i;
  assign in_range_s  = bus_if.in_addr_i < mem_els_lp;
  assign mem_idx_s   = bus_if.in_addr_i[mem_addr_width_lp-1:0];
  assign mem_re_s    = yumi_s & in_range_s & (~bus_if.in_we_i | bus_if.in_amo_swap_i);
  assign oob_count_d = (oob_count_q == 16'hFFFF) ? oob_count_q : oob_count_q + 16'd1;

  // SRAM write-port selection: masked store from IDLE, full-word swap write from AMO_WR.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_be_s    = {byte_lp{1'b0}};
    mem_widx_s  = mem_idx_s;
    mem_wdata_s = bus_if.in_data_i;
    case (state_q)
      IDLE: begin
        if (yumi_s & in_range_s & bus_if.in_we_i & ~bus_if.in_amo_swap_i) begin
          mem_we_s = 1'b1;
          mem_be_s = bus_if.in_mask_i;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      AMO_WR: begin
        if (~reset_i) begin
          mem_we_s    = 1'b1;
          mem_be_s    = {byte_lp{1'b1}};
          mem_widx_s  = amo_addr_q;
          mem_wdata_s = amo_data_q;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: mem_we_s = 1'b0;
    endcase
  end

  // Synchronous single-port SRAM; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      for (int b = 0; b < byte_lp; b++) begin
        if (mem_be_s[b]) begin
          mem_q[mem_widx_s][8*b +: 8] <= mem_wdata_s[8*b +: 8];
        end
      end
    end
    if (mem_re_s) begin
      rdata_q <= mem_q[mem_idx_s];
    end
  end

  // Control FSM with registered response valid, response kind and saturating OOB counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      returning_v_q <= 1'b0;
      resp_kind_q   <= RESP_ZERO;
      load_info_q   <= 5'd0;
      oob_count_q   <= 16'd0;
      amo_addr_q    <= {mem_addr_width_lp{1'b0}};
      amo_data_q    <= {data_width_p{1'b0}};
    end else begin
      returning_v_q <= yumi_s;
      case (state_q)
        IDLE: begin
          if (yumi_s) begin
            load_info_q <= bus_if.in_load_info_i;
            amo_addr_q  <= mem_idx_s;
            amo_data_q  <= bus_if.in_data_i;
            if (!in_range_s) begin
              resp_kind_q <= RESP_ZERO;
              oob_count_q <= oob_count_d;
            end else if (bus_if.in_we_i && bus_if.in_amo_swap_i) begin
              resp_kind_q <= RESP_WORD;
              state_q     <= AMO_WR;
            end else if (bus_if.in_we_i) begin
              resp_kind_q <= RESP_ZERO;
            end else begin
              resp_kind_q <= RESP_LOAD;
            end
          end else begin
            resp_kind_q <= RESP_ZERO;
          end
        end
        AMO_WR: begin
          state_q     <= IDLE;
          resp_kind_q <= RESP_ZERO;
        end
        default: begin
          state_q     <= IDLE;
          resp_kind_q <= RESP_ZERO;
        end
      endcase
    end
  end

  // Byte/halfword lane pick for narrow loads.
  always_comb begin
    byte_s = rdata_q[7:0];
    case (load_info_q[1:0])
      2'd0:    byte_s = rdata_q[7:0];
      2'd1:    byte_s = rdata_q[15:8];
      2'd2:    byte_s = rdata_q[23:16];
      2'd3:    byte_s = rdata_q[31:24];
      default: byte_s = rdata_q[7:0];
    endcase
    if (load_info_q[1]) begin
      half_s = rdata_q[31:16];
    end else begin
      half_s = rdata_q[15:0];
    end
  end

  // Load extension and response data selection from registered request info.
  always_comb begin
    load_s      = rdata_q;
    resp_data_s = {data_width_p{1'b0}};
    if (load_info_q[3]) begin
      load_s = {{(data_width_p-8){~load_info_q[4] & byte_s[7]}}, byte_s};
    end else if (load_info_q[2]) begin
      load_s = {{(data_width_p-16){~load_info_q[4] & half_s[15]}}, half_s};
    end else begin
      load_s = rdata_q;
    end
    case (resp_kind_q)
      RESP_LOAD: resp_data_s = load_s;
      RESP_WORD: resp_data_s = rdata_q;
      RESP_ZERO: resp_data_s = {data_width_p{1'b0}};
      default:   resp_data_s = {data_width_p{1'b0}};
    endcase
  end

  assign bus_if.in_yumi_o        = yumi_s;
  assign bus_if.returning_v_o    = returning_v_q;
  assign bus_if.returning_data_o = resp_data_s;
  assign bus_if.oob_count_o      = oob_count_q;
endmodule
